// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, address/colour types and the clear FSM
// state encoding used by the write-port arbiter.
package fb_pkg;
  localparam int FB_WIDTH  = 256;
  localparam int FB_HEIGHT = 240;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ABITS  = 16;
  localparam int FB_CBITS  = 6;

  typedef logic [FB_ABITS-1:0] fb_addr_t;
  typedef logic [FB_CBITS-1:0] fb_color_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;
endpackage

// File: rtl/fb_clear_seq.sv
// Full-frame clear sequencer: walks every framebuffer address once with a
// latched colour, advancing only on the cycles the arbiter grants it.
module fb_clear_seq
  import fb_pkg::*;
#(
  parameter int PIXELS = FB_PIXELS,
  parameter int ABITS  = FB_ABITS,
  parameter int CBITS  = FB_CBITS
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [CBITS-1:0] color,
  input  logic             grant,
  output logic             req,
  output logic [ABITS-1:0] addr,
  output logic [CBITS-1:0] data,
  output logic             busy,
  output logic             done
);
  localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(PIXELS - 1);

  clr_state_t state;

  // busy/done are registered alongside the state, so together they expose it:
  // busy=0 -> IDLE, busy=1 done=0 -> CLEAR, busy=1 done=1 -> DONE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      addr  <= '0;
      data  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            addr  <= '0;
            data  <= color;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (grant) begin
            // The last address holds rather than wrapping.
            if (addr == LAST_ADDR) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req = (state == CLEAR);
endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer BRAM port-A write arbiter: pixel stream > loader > clear,
// one registered write per cycle.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int CBITS  = FB_CBITS,
  parameter int ABITS  = FB_ABITS
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pix_we,
  input  logic [ABITS-1:0] pix_addr,
  input  logic [CBITS-1:0] pix_data,
  input  logic             ldr_valid,
  output logic             ldr_ready,
  input  logic [ABITS-1:0] ldr_addr,
  input  logic [CBITS-1:0] ldr_data,
  input  logic             clr_start,
  input  logic [CBITS-1:0] clr_color,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_addr,
  output logic [CBITS-1:0] mem_wdata
);
  localparam int PIXELS = WIDTH * HEIGHT;
  localparam logic [ABITS:0] PIX_LIMIT = (ABITS + 1)'(PIXELS);

  logic             pix_ok;
  logic             ldr_ok;
  logic             ldr_xfer;
  logic             clr_req;
  logic             clr_grant;
  logic [ABITS-1:0] clr_addr;
  logic [CBITS-1:0] clr_data;

  // Loader handshake: a transfer happens when ldr_valid & ldr_ready, and
  // ldr_ready is low whenever the pixel stream writes or reset is held.
  // Out-of-range transfers still complete; only the BRAM write is dropped.
  assign ldr_ready = resetn & ~pix_we;
  assign ldr_xfer  = ldr_valid & ldr_ready;
  assign pix_ok    = {1'b0, pix_addr} < PIX_LIMIT;
  assign ldr_ok    = {1'b0, ldr_addr} < PIX_LIMIT;
  // Any pixel strobe or loader transfer holds the clear, even if it is dropped.
  assign clr_grant = clr_req & ~pix_we & ~ldr_xfer;

  fb_clear_seq #(
    .PIXELS(PIXELS),
    .ABITS (ABITS),
    .CBITS (CBITS)
  ) u_clear_seq (
    .clk   (clk),
    .resetn(resetn),
    .start (clr_start),
    .color (clr_color),
    .grant (clr_grant),
    .req   (clr_req),
    .addr  (clr_addr),
    .data  (clr_data),
    .busy  (clr_busy),
    .done  (clr_done)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (pix_we && pix_ok) begin
      mem_we    <= 1'b1;
      mem_addr  <= pix_addr;
      mem_wdata <= pix_data;
    end else if (ldr_xfer && ldr_ok) begin
      mem_we    <= 1'b1;
      mem_addr  <= ldr_addr;
      mem_wdata <= ldr_data;
    end else if (clr_grant) begin
      mem_we    <= 1'b1;
      mem_addr  <= clr_addr;
      mem_wdata <= clr_data;
    end else begin
      mem_we <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomised scoreboard bench for fb_write_arbiter: a frame-level model
// predicts every BRAM write, the monitor pops and compares on mem_we.
module tb_fb_write_arbiter;
  localparam int PIX = 256 * 240;
  localparam int MAX_CYC = 95000;

  logic        clk;
  logic        resetn;
  logic        pix_we;
  logic [15:0] pix_addr;
  logic [5:0]  pix_data;
  logic        ldr_valid;
  logic        ldr_ready;
  logic [15:0] ldr_addr;
  logic [5:0]  ldr_data;
  logic        clr_start;
  logic [5:0]  clr_color;
  logic        clr_busy;
  logic        clr_done;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [5:0]  mem_wdata;

  fb_write_arbiter dut (
    .clk      (clk),
    .resetn   (resetn),
    .pix_we   (pix_we),
    .pix_addr (pix_addr),
    .pix_data (pix_data),
    .ldr_valid(ldr_valid),
    .ldr_ready(ldr_ready),
    .ldr_addr (ldr_addr),
    .ldr_data (ldr_data),
    .clr_start(clr_start),
    .clr_color(clr_color),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [22:0] exp_q[$];       // {clr_done, addr, data}
  logic        exp_ready = 1'b0;
  logic        exp_busy  = 1'b0;
  logic        started   = 1'b0;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          done_cyc = -1;

  // Frame-level clear model: a clear is a run of PIX writes in address
  // order, one per otherwise-free cycle, followed by one cool-down cycle.
  logic        m_active = 1'b0;
  logic        m_cool   = 1'b0;
  int          m_addr   = 0;
  logic [5:0]  m_color  = '0;
  int          start_cyc = 0;
  int          contend   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rn, input logic pw, input logic [15:0] pa,
                       input logic [5:0] pd, input logic lv, input logic [15:0] la,
                       input logic [5:0] ld, input logic cs, input logic [5:0] cc);
    logic was_idle;
    logic next_cool;
    @(posedge clk);
    #1;
    resetn = rn; pix_we = pw; pix_addr = pa; pix_data = pd;
    ldr_valid = lv; ldr_addr = la; ldr_data = ld;
    clr_start = cs; clr_color = cc;
    started   = 1'b1;
    exp_ready = rn & ~pw;
    exp_busy  = m_active | m_cool;
    if (!rn) begin
      m_active = 1'b0;
      m_cool   = 1'b0;
      return;
    end
    was_idle  = !m_active && !m_cool;
    next_cool = 1'b0;
    if (pw) begin
      if (pa < PIX) exp_q.push_back({1'b0, pa, pd});
      if (m_active) contend++;
    end else if (lv) begin
      if (la < PIX) exp_q.push_back({1'b0, la, ld});
      if (m_active) contend++;
    end else if (m_active) begin
      exp_q.push_back({m_addr == PIX - 1, m_addr[15:0], m_color});
      if (m_addr == PIX - 1) begin
        m_active  = 1'b0;
        next_cool = 1'b1;
      end else begin
        m_addr++;
      end
    end
    m_cool = next_cool;
    if (cs && was_idle) begin
      m_active  = 1'b1;
      m_addr    = 0;
      m_color   = cc;
      start_cyc = cyc;
      contend   = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 16'h0, 6'h0, 0, 16'h0, 6'h0, 0, 6'h0);
  endtask

  // ---------------- monitor ----------------
  logic        rst_prev = 1'b0;
  logic [21:0] last_ad  = '0;
  logic [22:0] e;

  always @(negedge clk) begin
    if (cyc > MAX_CYC) begin
      $display("FAIL watchdog: got cycle %0d expected below %0d", cyc, MAX_CYC);
      $fatal(1, "watchdog expired");
    end
    if (started) begin
      chk("ldr_ready", ldr_ready, exp_ready);
      chk("clr_busy", clr_busy, exp_busy);
      if (!rst_prev) begin
        chk("we_after_reset", mem_we, 0);
        last_ad = '0;
      end
      if (mem_we !== 1'b0) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write (cycle %0d)",
                   mem_addr, mem_wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("write", {clr_done, mem_addr, mem_wdata}, e);
          last_ad = e[21:0];
        end
      end else begin
        chk("done_without_we", clr_done, 0);
        chk("hold", {mem_addr, mem_wdata}, last_ad);
      end
      if (clr_done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
    end
    rst_prev = resetn;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    resetn = 1'b0; pix_we = 1'b1; pix_addr = 16'h0010; pix_data = 6'h03;
    ldr_valid = 1'b1; ldr_addr = 16'h0020; ldr_data = 6'h04;
    clr_start = 1'b1; clr_color = 6'h09;

    // Reset hold with every requester active.
    for (int i = 0; i < 5; i++) drive(0, 1, 16'h0010, 6'h03, 1, 16'h0020, 6'h04, 1, 6'h09);
    idle(2);

    // Pixel beats loader; loader lands the cycle after pix_we drops.
    drive(1, 1, 16'h0103, 6'h21, 1, 16'h0200, 6'h05, 0, 6'h0);
    drive(1, 0, 16'h0000, 6'h00, 1, 16'h0200, 6'h05, 0, 6'h0);
    idle(1);

    // Out-of-range and last-in-range addresses.
    drive(1, 1, 16'hF000, 6'h11, 0, 16'h0, 6'h0, 0, 6'h0);
    drive(1, 0, 16'h0, 6'h0, 1, 16'hFFFF, 6'h12, 0, 6'h0);
    drive(1, 1, 16'hEFFF, 6'h13, 0, 16'h0, 6'h0, 0, 6'h0);
    drive(1, 0, 16'h0, 6'h0, 1, 16'hEFFF, 6'h14, 0, 6'h0);
    idle(2);

    // Random pixel/loader traffic with the clear idle.
    for (int i = 0; i < 300; i++)
      drive(1, $urandom_range(0, 3) == 0, 16'($urandom_range(0, 65535)), 6'($urandom_range(0, 63)),
            $urandom_range(0, 1) == 1, 16'($urandom_range(0, 65535)), 6'($urandom_range(0, 63)),
            0, 6'h0);
    idle(2);

    // Clear interrupted by reset at address 0x1234.
    drive(1, 0, 16'h0, 6'h0, 0, 16'h0, 6'h0, 1, 6'h2A);
    n = 0;
    while (!(m_active && m_addr == 16'h1234) && n < 20000) begin
      drive(1, (n % 8) == 3, 16'($urandom_range(0, PIX - 1)), 6'($urandom_range(0, 63)),
            0, 16'h0, 6'h0, 0, 6'h0);
      n++;
    end
    chk("reached_0x1234", m_addr, 32'h1234);
    drive(0, 0, 16'h0, 6'h0, 0, 16'h0, 6'h0, 0, 6'h0);
    drive(0, 0, 16'h0, 6'h0, 0, 16'h0, 6'h0, 0, 6'h0);
    idle(3);

    // Full clear: uncontended first half, then pixel every 4th cycle plus
    // sparse loader writes; clr_start pulses mid-clear must be ignored.
    done_cyc = -1;
    drive(1, 0, 16'h0, 6'h0, 0, 16'h0, 6'h0, 1, 6'h0D);
    n = 0;
    while (m_active && n < 80000) begin
      drive(1, (n >= 30000) && (n % 4 == 0), 16'($urandom_range(0, PIX - 1)),
            6'($urandom_range(0, 63)),
            (n >= 30000) && ($urandom_range(0, 15) == 0), 16'($urandom_range(0, PIX - 1)),
            6'($urandom_range(0, 63)),
            (n % 5000) == 7, 6'h3F);
      n++;
    end
    idle(5);
    chk("clear_duration", done_cyc - start_cyc, PIX + 1 + contend);
    chk("done_count", n_done, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Arbitrates the single framebuffer BRAM write port (port A, `clk` domain) between three requesters: the live GameTank pixel stream, a handshaked loader for background/menu images, and a built-in clear sequencer that fills the whole frame with one colour. It sits between the pixel capture logic and the framebuffer memory in the GameTank-to-HDMI path. The read side (HDMI scaler) is unaffected.

## Interface
Parameters:
- `WIDTH`, 256, framebuffer width in pixels
- `HEIGHT`, 240, framebuffer height in lines
- `CBITS`, 6, colour index width
- `ABITS`, 16, address width; `WIDTH*HEIGHT` must be ≤ 2**ABITS

Ports:
- `clk`  in  1  GameTank clock. Single clock domain.
- `resetn`  in  1  reset. Synchronous, active-low.
- `pix_we`  in  1  pixel-stream write strobe. No backpressure.
- `pix_addr`  in  ABITS  pixel address, `{line, column}`.
- `pix_data`  in  CBITS  pixel colour.
- `ldr_valid`  in  1  loader write request.
- `ldr_ready`  out  1  loader request accepted this cycle.
- `ldr_addr`  in  ABITS  loader address.
- `ldr_data`  in  CBITS  loader colour.
- `clr_start`  in  1  start a full-frame clear. Level is sampled each cycle.
- `clr_color`  in  CBITS  fill colour, latched at start.
- `clr_busy`  out  1  clear in progress.
- `clr_done`  out  1  one-cycle pulse when the clear completes.
- `mem_we`  out  1  BRAM port A write enable.
- `mem_addr`  out  ABITS  BRAM port A address.
- `mem_wdata`  out  CBITS  BRAM port A data.

## Operation
- Fixed priority: pixel > loader > clear. At most one grant per cycle.
- Pixel stream:
  - Always granted when `pix_we`=1.
  - Dropped silently if `pix_addr` ≥ `WIDTH*HEIGHT`.
- Loader:
  - `ldr_ready = resetn & ~pix_we`. This is combinational; it is the only comb path from inputs to outputs.
  - A transfer occurs when `ldr_valid & ldr_ready`.
  - If the address is out of range, the handshake still completes but the write is suppressed.
  - The loader may drop `ldr_valid` at any time. No ordering guarantee versus clear writes.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: when `clr_start`=1, latch `clr_color`, set `clr_addr`=0, go to CLEAR.
  - CLEAR: granted only when there is no pixel write and no loader transfer. Each grant writes `clr_addr` and increments it. The grant with `clr_addr == WIDTH*HEIGHT-1` moves the FSM to DONE.
  - DONE: `clr_done`=1 for this cycle only, then IDLE.
  - `clr_start` is ignored in CLEAR and DONE; no queueing.
- `clr_addr` is `ABITS` wide. It never wraps past `WIDTH*HEIGHT-1`.
- Reset mid-clear: FSM returns to IDLE, no `clr_done`, and any pending grant is discarded.

## Timing
- All `mem_*` outputs are registered. A write granted in cycle t appears on `mem_*` in cycle t+1.
- When no write is granted, `mem_we`=0 and `mem_addr`/`mem_wdata` hold their last values.
- `clr_busy` is high in CLEAR and DONE.
  - It rises in the cycle after `clr_start` is sampled in IDLE.
  - It falls in the cycle after DONE.
- `clr_done` coincides with `mem_we` of the final clear pixel.
- Uncontended clear: `WIDTH*HEIGHT` = 61440 write cycles. The first clear write appears 2 cycles after `clr_start`.
- Contended clear: each pixel or loader grant adds exactly one cycle.
- Reset values:
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `clr_busy`=0, `clr_done`=0.
  - `ldr_ready`=0 while `resetn`=0.
- Throughput: one BRAM write per cycle maximum. The pixel stream is never stalled or delayed beyond the 1-cycle register.

## Structure
- Package `fb_pkg` holds:
  - `FB_WIDTH`, `FB_HEIGHT`, `FB_PIXELS`.
  - `fb_addr_t` (logic[ABITS-1:0]) and `fb_color_t` (logic[CBITS-1:0]).
  - `clr_state_t` enum {IDLE, CLEAR, DONE}.
- Sub-module `fb_clear_seq` owns the clear FSM, address counter and colour latch.
  - Inputs: `start`, `color`, `grant`.
  - Outputs: `req`, `addr`, `data`, `busy`, `done`.
- The arbiter mux and output register stay in `fb_write_arbiter`.

## Test plan
- Reset hold: `resetn`=0 for 5 cycles with all requests active -> `mem_we`=0, `ldr_ready`=0, `clr_busy`=0 throughout.
- Pixel priority: `pix_we`=1 (addr 0x0103, data 0x21) and `ldr_valid`=1 (addr 0x0200, data 0x05) in the same cycle.
  - Next cycle: `mem_addr`=0x0103, `mem_wdata`=0x21.
  - `ldr_ready`=0 in the conflict cycle; the loader write lands one cycle after `pix_we` drops.
- Uncontended clear: `clr_start` with `clr_color`=0x0D.
  - Exactly 61440 `mem_we` pulses, addresses 0..0xEFFF ascending, all data 0x0D.
  - `clr_done` pulses once, in the same cycle as the write to 0xEFFF.
- Contended clear: `pix_we` every 4th cycle during the clear.
  - Clear writes are never lost; total duration = 61440 + number of pixel writes.
  - No address is skipped or repeated.
- Out-of-range handling:
  - `pix_addr`=0xF000 -> no `mem_we`.
  - `ldr_addr`=0xFFFF -> `ldr_ready`=1 but no `mem_we`.
- Reset and restart:
  - Reset asserted at clear address 0x1234 -> `clr_busy`=0 and no `clr_done`.
  - A subsequent `clr_start` restarts at address 0.
  - `clr_start` pulsed during CLEAR has no effect.
